// File: rtl/relu_pack_pkg.sv
// Shared widths and FSM state encoding for the ReLU/pack activation stage.
package relu_pack_pkg;
  localparam int IN_W  = 16;
  localparam int ACT_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;
endpackage

// File: rtl/relu_pack_ctrl_relu_out.sv
// ReLU_out: per-element activation datapath.
// Negative accumulators go to zero, others truncate to the low byte with no
// saturation; an optional signed ceiling then clips the result.
import relu_pack_pkg::*;

module ReLU_out (
  input  logic signed [IN_W-1:0]  in_data,
  input  logic                    cmp_flag,
  input  logic signed [ACT_W-1:0] cmp_val,
  output logic signed [ACT_W-1:0] out_data
);

  logic signed [ACT_W-1:0] w_relu;

  // ReLU by truncation followed by the optional signed upper clip
  always_comb begin
    w_relu   = in_data[IN_W-1] ? '0 : ACT_W'(in_data);
    out_data = (cmp_flag && (w_relu > cmp_val)) ? cmp_val : w_relu;
  end

endmodule

// File: rtl/relu_pack_ctrl.sv
// relu_pack_ctrl: frame controller for the activation stage.
// Accepts a frame of 16-bit accumulator values, runs each through ReLU_out,
// packs LANES bytes per output word (first element in the lowest byte) and
// streams the words out with keep/last marking and a done pulse.
// Optional build macro RELU_PACK_STATS_EN adds zeroed/clipped element counters.
import relu_pack_pkg::*;

module relu_pack_ctrl #(
  parameter int LANES = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_start,
  input  logic [CNT_W-1:0]         cfg_len,
  input  logic                     cfg_clip_en,
  input  logic [7:0]               cfg_clip_val,
  output logic                     busy,
  output logic                     done,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [15:0]       in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [8*LANES-1:0]       out_data,
  output logic [LANES-1:0]         out_keep,
  output logic                     out_last
`ifdef RELU_PACK_STATS_EN
  ,
  output logic [CNT_W-1:0]         stat_zeroed,
  output logic [CNT_W-1:0]         stat_clipped
`endif
);

  localparam int             LW        = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [LW-1:0]  LAST_LANE = LW'(LANES - 1);

  state_t                  r_state;
  logic [CNT_W-1:0]        r_remaining;
  logic [LW-1:0]           r_lane;
  logic [8*LANES-1:0]      r_pack;
  logic [8*LANES-1:0]      r_out_data;
  logic [LANES-1:0]        r_out_keep;
  logic                    r_out_valid;
  logic                    r_out_last;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_clip_en;
  logic signed [ACT_W-1:0] r_clip_val;

  logic signed [ACT_W-1:0] w_act;
  logic                    w_out_free;
  logic                    w_last_elem;
  logic                    w_word_done;
  logic                    w_in_ready;
  logic                    w_accept;
  logic                    w_start;
  logic [8*LANES-1:0]      w_merged;
  logic [LANES-1:0]        w_keep;

  ReLU_out u_relu (
    .in_data  (in_data),
    .cmp_flag (r_clip_en),
    .cmp_val  (r_clip_val),
    .out_data (w_act)
  );

  // Handshake qualification, pack-buffer merge and keep mask for the current lane
  always_comb begin
    w_out_free  = !r_out_valid || out_ready;
    w_last_elem = (r_remaining == CNT_W'(1));
    w_word_done = (r_lane == LAST_LANE) || w_last_elem;
    // an element that would launch a word waits until the output register frees up
    w_in_ready  = (r_state == RUN) && (r_remaining != '0) && (w_out_free || !w_word_done);
    w_accept    = in_valid && w_in_ready;
    w_start     = cfg_start && (r_state == IDLE);
    w_merged    = r_pack;
    w_merged[r_lane*ACT_W +: ACT_W] = w_act;
    for (int i = 0; i < LANES; i++) begin
      w_keep[i] = (i <= int'(r_lane));
    end
  end

  // Frame FSM, counters, pack buffer and output word register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_lane      <= '0;
      r_pack      <= '0;
      r_out_data  <= '0;
      r_out_keep  <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_clip_en   <= 1'b0;
      r_clip_val  <= '0;
    end else begin
      r_done <= 1'b0;
      // the current word leaves on its handshake; a new transfer below overrides this
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (w_start) begin
            r_clip_en   <= cfg_clip_en;
            r_clip_val  <= cfg_clip_val;
            r_remaining <= cfg_len;
            r_lane      <= '0;
            r_pack      <= '0;
            r_busy      <= 1'b1;
            if (cfg_len == '0) begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          if (w_accept) begin
            r_remaining <= r_remaining - 1'b1;
            if (w_word_done) begin
              r_out_valid <= 1'b1;
              r_out_data  <= w_merged;
              r_out_keep  <= w_keep;
              r_out_last  <= w_last_elem;
              r_pack      <= '0;
              r_lane      <= '0;
            end else begin
              r_pack <= w_merged;
              r_lane <= r_lane + 1'b1;
            end
            if (w_last_elem) begin
              r_state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // only the final word can be pending here
          if (r_out_valid && out_ready) begin
            r_state <= DONE;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_keep  = r_out_keep;
  assign out_last  = r_out_last;

`ifdef RELU_PACK_STATS_EN
  logic [CNT_W-1:0]        r_stat_zeroed;
  logic [CNT_W-1:0]        r_stat_clipped;
  logic                    w_zeroed;
  logic                    w_clipped;
  logic signed [ACT_W-1:0] w_relu_raw;

  // Classify the element being offered: zeroed by ReLU, or replaced by the ceiling
  always_comb begin
    w_zeroed   = in_data[IN_W-1];
    w_relu_raw = w_zeroed ? '0 : ACT_W'(in_data);
    w_clipped  = r_clip_en && (w_relu_raw > r_clip_val);
  end

  // Saturating per-frame statistics, cleared on start and held after the frame
  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_stat_zeroed  <= '0;
      r_stat_clipped <= '0;
    end else if (w_accept) begin
      if (w_zeroed && !(&r_stat_zeroed)) begin
        r_stat_zeroed <= r_stat_zeroed + 1'b1;
      end
      if (w_clipped && !(&r_stat_clipped)) begin
        r_stat_clipped <= r_stat_clipped + 1'b1;
      end
    end
  end

  assign stat_zeroed  = r_stat_zeroed;
  assign stat_clipped = r_stat_clipped;
`endif

endmodule

// File: tb/tb_relu_pack_ctrl.sv
// Scoreboard bench for relu_pack_ctrl: directed frames push their expected
// packed words into a queue; a monitor pops and compares on every handshake.
`timescale 1ns/1ps

module tb_relu_pack_ctrl;

  localparam int LANES = 4;
  localparam int CNT_W = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_start;
  logic [CNT_W-1:0]  cfg_len;
  logic              cfg_clip_en;
  logic [7:0]        cfg_clip_val;
  logic              busy;
  logic              done;
  logic              in_valid;
  logic              in_ready;
  logic signed [15:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [8*LANES-1:0] out_data;
  logic [LANES-1:0]  out_keep;
  logic              out_last;

  relu_pack_ctrl #(.LANES(LANES), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_start    (cfg_start),
    .cfg_len      (cfg_len),
    .cfg_clip_en  (cfg_clip_en),
    .cfg_clip_val (cfg_clip_val),
    .busy         (busy),
    .done         (done),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_keep     (out_keep),
    .out_last     (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } word_t;

  word_t exp_q[$];
  int    n_cmp = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    start_cyc = 0;
  int    last_hs_cyc = -100;
  int    acc_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] k, input logic l);
    word_t w;
    w.data = d;
    w.keep = k;
    w.last = l;
    exp_q.push_back(w);
  endtask

  // Monitor: every output handshake must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_word", {out_data, out_keep, out_last}, 0);
      end else begin
        word_t e;
        e = exp_q.pop_front();
        check("out_word", {out_data, out_keep, out_last}, {e.data, e.keep, e.last});
      end
      if (out_last) last_hs_cyc = cyc;
    end
  end

  task automatic do_start(input logic [15:0] len, input logic ce, input logic [7:0] cv);
    cfg_start    = 1'b1;
    cfg_len      = len;
    cfg_clip_en  = ce;
    cfg_clip_val = cv;
    start_cyc    = cyc;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic send(input logic [15:0] v);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = v;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk); #1;
      if (ok) break;
    end
    if (!ok) check("accept_timeout", 0, 1);
    else acc_cnt++;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input bit from_start);
    bit seen;
    int ref_c;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      check("done_timeout", 0, 1);
    end else begin
      ref_c = from_start ? start_cyc : last_hs_cyc;
      check("done_latency", 64'(cyc - ref_c), 1);
      check("done_no_word", out_valid, 0);
    end
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
  endtask

  task automatic stall_proc();
    bit seen;
    logic [36:0] snap;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("stall_no_word", 0, 1);
    snap = {out_data, out_keep, out_last};
    repeat (5) begin
      @(negedge clk);
      check("stall_hold", {out_valid, out_data, out_keep, out_last}, {1'b1, snap});
    end
    check("stall_accepted", acc_cnt, 7);
    check("stall_in_ready", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
  endtask

  initial begin
    int dones;
    rst = 1'b1; cfg_start = 1'b0; cfg_len = '0; cfg_clip_en = 1'b0; cfg_clip_val = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_keep", out_keep, 0);
    @(posedge clk); #1;

    // Frame 1: eight ascending values, no clip
    push(32'h04030201, 4'hF, 1'b0);
    push(32'h08070605, 4'hF, 1'b1);
    last_hs_cyc = -100;
    do_start(16'd8, 1'b0, 8'h00);
    check("busy_after_start", busy, 1);
    for (int i = 1; i <= 8; i++) send(16'(i));
    wait_done(1'b0);

    // Frame 2: negative inputs, truncation, partial final word
    push(32'h05FF1200, 4'hF, 1'b0);
    push(32'h00000000, 4'h1, 1'b1);
    last_hs_cyc = -100;
    do_start(16'd5, 1'b0, 8'h00);
    send(16'hFFFD); send(16'h0012); send(16'h7FFF); send(16'h0005); send(16'hFFFF);
    wait_done(1'b0);

    // Frame 3: clip at 0x10, with an ignored start pulse mid-frame
    push(32'h10100810, 4'hF, 1'b1);
    last_hs_cyc = -100;
    do_start(16'd4, 1'b1, 8'h10);
    send(16'h0020); send(16'h0008);
    do_start(16'd2, 1'b0, 8'h00);
    send(16'h0010); send(16'h007F);
    wait_done(1'b0);

    // Frame 4: signed clip compare (0x80 and 0xF0 are negative bytes)
    push(32'h0110F080, 4'hF, 1'b1);
    last_hs_cyc = -100;
    do_start(16'd4, 1'b1, 8'h10);
    send(16'h0080); send(16'h00F0); send(16'h0011); send(16'h0001);
    wait_done(1'b0);

    // Frame 5: downstream back-pressure mid-frame
    push(32'h13121110, 4'hF, 1'b0);
    push(32'h17161514, 4'hF, 1'b0);
    push(32'h1B1A1918, 4'hF, 1'b1);
    last_hs_cyc = -100;
    out_ready = 1'b0;
    acc_cnt = 0;
    do_start(16'd12, 1'b0, 8'h00);
    fork
      begin
        for (int i = 0; i < 12; i++) send(16'(16'h0010 + i));
      end
      stall_proc();
    join
    wait_done(1'b0);

    // Frame 6: zero-length frame
    do_start(16'd0, 1'b0, 8'h00);
    wait_done(1'b1);

    // Frame 7: reset after three elements, then a clean frame
    do_start(16'd8, 1'b0, 8'h00);
    send(16'h0001); send(16'h0002); send(16'h0003);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_out_keep", out_keep, 0);
    check("midrst_out_last", out_last, 0);
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("midrst_no_done", dones, 0);
    @(posedge clk); #1;
    push(32'h44332211, 4'hF, 1'b1);
    last_hs_cyc = -100;
    do_start(16'd4, 1'b0, 8'h00);
    send(16'h0011); send(16'h0022); send(16'h0033); send(16'h0044);
    wait_done(1'b0);

    repeat (3) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
